change_detect_ctrl: RTL

Control/issuer side of the 3-bit counter instruction interface. Latches a DATA_W-bit word on start and emits LOAD once. Then scans the word LSB-first, one adjacent bit pair per cycle, and emits CHNG for every 0->1 transition. The instruction output drives the transition counter unit directly; the counter's result then holds the number of rising transitions in the word.

---
 rtl/change_pkg.sv | 21 ++
 rtl/scan_shifter.sv | 38 +++
 rtl/change_detect_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/change_pkg.sv
// change_pkg: instruction codes shared with the transition counter
// unit, plus the 2-bit FSM state encoding of change_detect_ctrl.
package change_pkg;

  localparam logic [2:0] INSTR_NOP  = 3'b000;
  localparam logic [2:0] INSTR_LOAD = 3'b100;
  localparam logic [2:0] INSTR_CHNG = 3'b001;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_SCAN = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_LOAD = ST_LOAD,
    S_SCAN = ST_SCAN,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/scan_shifter.sv
// scan_shifter: holds the latched word minus its LSB and the previous
// bit; rise_o flags a 0->1 step between prev and the next word bit.
// Ports: clk_i, rst_ni (sync, active-low), load_i/data_i latch a word,
// shift_i advances one pair, rise_o pair flag, last_o previous bit.
module scan_shifter #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              rise_o,
  output logic              last_o
);

  logic [DATA_W-2:0] word_q;
  logic              prev_q;

  // Load pre-consumes bit 0, so rise_o presents pair 1 right away.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      word_q <= '0;
      prev_q <= 1'b0;
    end else if (load_i) begin
      prev_q <= data_i[0];
      word_q <= data_i[DATA_W-1:1];
    end else if (shift_i) begin
      prev_q <= word_q[0];
      word_q <= word_q >> 1;
    end
  end

  assign rise_o = ~prev_q & word_q[0];
  // After the final pair has been issued prev_q is the word MSB.
  assign last_o = prev_q;

endmodule

// File: rtl/change_detect_ctrl.sv
// change_detect_ctrl: latches a word on start, issues LOAD then one
// CHNG per 0->1 bit step (LSB first), then a one-cycle done pulse.
// Ports: clock, reset (sync, active-low), start, data_in, new_seq in;
// instruction[2:0], busy, done out (all registered).
// Optional macro CHANGE_CHAIN_EN: carries the last MSB across words.
module change_detect_ctrl
  import change_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IDX_W  = $clog2(DATA_W)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              new_seq,
  output logic [2:0]        instruction,
  output logic              busy,
  output logic              done
);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [2:0]       instr_q;
  logic             busy_q;
  logic             done_q;
  logic             load_d;
  logic             shift_d;
  logic             rise;
  logic             last_bit;

  always_comb begin
    load_d  = (state_q == S_IDLE) && start;
    shift_d = (state_q == S_LOAD) ||
              ((state_q == S_SCAN) && (idx_q != IDX_LAST));
  end

  scan_shifter #(
    .DATA_W (DATA_W)
  ) u_shift (
    .clk_i   (clock),
    .rst_ni  (reset),
    .load_i  (load_d),
    .shift_i (shift_d),
    .data_i  (data_in),
    .rise_o  (rise),
    .last_o  (last_bit)
  );

`ifdef CHANGE_CHAIN_EN
  logic carry_q;
  logic cvld_q;
  logic chain;

  assign chain = !new_seq && cvld_q;
`else
  logic unused_in;

  assign unused_in = new_seq ^ last_bit;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      instr_q <= INSTR_NOP;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef CHANGE_CHAIN_EN
      carry_q <= 1'b0;
      cvld_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          instr_q <= INSTR_NOP;
          if (start) begin
            busy_q  <= 1'b1;
            idx_q   <= '0;
            state_q <= S_LOAD;
            instr_q <= INSTR_LOAD;
`ifdef CHANGE_CHAIN_EN
            // Chained word: pair 0 is (carry, data_in[0]), no LOAD.
            if (chain) begin
              state_q <= S_SCAN;
              instr_q <= (!carry_q && data_in[0]) ?
                         INSTR_CHNG : INSTR_NOP;
            end
`endif
          end
        end
        S_LOAD: begin
          state_q <= S_SCAN;
          idx_q   <= IDX_ONE;
          instr_q <= rise ? INSTR_CHNG : INSTR_NOP;
        end
        S_SCAN: begin
          if (idx_q == IDX_LAST) begin
            state_q <= S_DONE;
            instr_q <= INSTR_NOP;
            done_q  <= 1'b1;
          end else begin
            idx_q   <= idx_q + IDX_ONE;
            instr_q <= rise ? INSTR_CHNG : INSTR_NOP;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          instr_q <= INSTR_NOP;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
`ifdef CHANGE_CHAIN_EN
          carry_q <= last_bit;
          cvld_q  <= 1'b1;
`endif
        end
      endcase
    end
  end

  assign instruction = instr_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule
